// File: rtl/alu_pkg.sv
// rtl/alu_pkg.sv - shared ALU opcodes and multiply-sequencer state encoding
package alu_pkg;

    localparam logic [3:0] ALU_AND = 4'b0000;
    localparam logic [3:0] ALU_OR  = 4'b0001;
    localparam logic [3:0] ALU_ADD = 4'b0010;
    localparam logic [3:0] ALU_SUB = 4'b0110;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } seq_state_t;

endpackage

// File: rtl/alu_mul_seq.sv
// rtl/alu_mul_seq.sv - shift-add MUL sequencer that borrows the shared ALU adder
module alu_mul_seq
    import alu_pkg::*;
#(
    parameter int N = 32
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         start,
    input  logic         kill,
    input  logic [N-1:0] rs1,
    input  logic [N-1:0] rs2,
    input  logic [N-1:0] alu_out,
    output logic         alu_req,
    output logic [3:0]   alu_sel,
    output logic [N-1:0] alu_a,
    output logic [N-1:0] alu_b,
    output logic         busy,
    output logic         done,
    output logic [N-1:0] product
);

    localparam int CW = $clog2(N);

    seq_state_t     state, state_nxt;
    logic [N-1:0]   acc, acc_nxt;
    logic [N-1:0]   mcand, mcand_nxt;
    logic [N-1:0]   mplier, mplier_nxt;
    logic [CW-1:0]  cnt, cnt_nxt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= ST_IDLE;
            acc     <= '0;
            mcand   <= '0;
            mplier  <= '0;
            cnt     <= '0;
            product <= '0;
        end else begin
            state  <= state_nxt;
            acc    <= acc_nxt;
            mcand  <= mcand_nxt;
            mplier <= mplier_nxt;
            cnt    <= cnt_nxt;
            // Capture on entry to DONE so a kill in the last RUN cycle leaves product untouched
            if (state_nxt == ST_DONE) begin
                product <= acc_nxt;
            end
        end
    end

    always_comb begin
        state_nxt  = state;
        acc_nxt    = acc;
        mcand_nxt  = mcand;
        mplier_nxt = mplier;
        cnt_nxt    = cnt;
        case (state)
            ST_IDLE: begin
                if (start) begin
                    acc_nxt    = '0;
                    mcand_nxt  = rs1;
                    mplier_nxt = rs2;
                    cnt_nxt    = '0;
                    state_nxt  = (rs2 == '0) ? ST_DONE : ST_RUN;
                end
            end
            ST_RUN: begin
                if (mplier[0]) begin
                    acc_nxt = alu_out;
                end
                mcand_nxt  = mcand << 1;
                mplier_nxt = mplier >> 1;
                cnt_nxt    = cnt + 1'b1;
                if (kill) begin
                    state_nxt = ST_IDLE;
                end else if ((mplier >> 1) == '0 || cnt == CW'(N - 1)) begin
                    state_nxt = ST_DONE;
                end
            end
            ST_DONE: begin
                state_nxt = ST_IDLE;
            end
            default: begin
                state_nxt = ST_IDLE;
            end
        endcase
    end

    // ALU steering is a pure decode of registered state; only alu_out feeds back combinationally
    assign alu_req = (state == ST_RUN);
    assign alu_sel = ALU_ADD;
    assign alu_a   = alu_req ? acc   : '0;
    assign alu_b   = alu_req ? mcand : '0;
    assign busy    = (state == ST_RUN) || (state == ST_DONE);
    assign done    = (state == ST_DONE);

endmodule

// File: tb/tb_alu_mul_seq.sv
// tb/tb_alu_mul_seq.sv - randomized self-checking bench for alu_mul_seq
module tb_alu_mul_seq;
    import alu_pkg::*;

    localparam int N = 32;

    logic         clk;
    logic         rst_n;
    logic         start;
    logic         kill;
    logic [N-1:0] rs1;
    logic [N-1:0] rs2;
    logic [N-1:0] alu_out;
    logic         alu_req;
    logic [3:0]   alu_sel;
    logic [N-1:0] alu_a;
    logic [N-1:0] alu_b;
    logic         busy;
    logic         done;
    logic [N-1:0] product;

    int vectors;
    int miscompares;
    logic [N-1:0] prev_prod;

    alu_mul_seq #(.N(N)) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .start   (start),
        .kill    (kill),
        .rs1     (rs1),
        .rs2     (rs2),
        .alu_out (alu_out),
        .alu_req (alu_req),
        .alu_sel (alu_sel),
        .alu_a   (alu_a),
        .alu_b   (alu_b),
        .busy    (busy),
        .done    (done),
        .product (product)
    );

    // Behavioural shared ALU, as the top level would present it
    assign alu_out = (alu_sel == ALU_ADD) ? alu_a + alu_b :
                     (alu_sel == ALU_SUB) ? alu_a - alu_b :
                     (alu_sel == ALU_OR)  ? (alu_a | alu_b) :
                                            (alu_a & alu_b);

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [N-1:0] got, input logic [N-1:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic int top_bits(input logic [N-1:0] v);
        int k = 0;
        for (int i = 0; i < N; i++) if (v[i]) k = i + 1;
        return k;
    endfunction

    task automatic check_reset_outputs(input string tag);
        check({tag, " alu_req"}, N'(alu_req), '0);
        check({tag, " busy"},    N'(busy), '0);
        check({tag, " done"},    N'(done), '0);
        check({tag, " product"}, product, '0);
        check({tag, " alu_sel"}, N'(alu_sel), N'(4'b0010));
        check({tag, " alu_a"},   alu_a, '0);
        check({tag, " alu_b"},   alu_b, '0);
    endtask

    // One multiply; mid_start/kill_at name the post-start cycle in which to pulse them (0 = never)
    task automatic run_op(input logic [N-1:0] a, input logic [N-1:0] b,
                          input int mid_start, input int kill_at);
        int k, reqs, done_cyc, exp_req, exp_done;
        logic [N-1:0] exp_prod;
        k = top_bits(b);
        exp_prod = a * b;
        reqs = 0;
        done_cyc = 0;
        @(negedge clk);
        start = 1'b1;
        rs1 = a;
        rs2 = b;
        for (int c = 1; c <= N + 2; c++) begin
            @(negedge clk);
            if (c == 1) check("busy_after_start", N'(busy), N'(1));
            if (alu_req) begin
                reqs++;
                check("alu_b_shift", alu_b, a << (c - 1));
            end
            if (done && done_cyc == 0) begin
                done_cyc = c;
                check("product_at_done", product, exp_prod);
            end
            if (kill_at != 0 && c == kill_at + 1) begin
                check("idle_after_kill", N'(busy), '0);
                check("product_after_kill", product, prev_prod);
            end
            start = (c == mid_start);
            if (c == mid_start) begin
                rs1 = 9;
                rs2 = 9;
            end
            kill = (c == kill_at);
        end
        start = 1'b0;
        kill = 1'b0;
        exp_req  = (kill_at != 0) ? kill_at : k;
        exp_done = (kill_at != 0) ? 0 : k + 1;
        check("run_cycles", N'(reqs), N'(exp_req));
        check("done_cycle", N'(done_cyc), N'(exp_done));
        check("product_final", product, (kill_at != 0) ? prev_prod : exp_prod);
        if (kill_at == 0) prev_prod = exp_prod;
    endtask

    initial begin
        logic [N-1:0] ra, rb;
        vectors = 0;
        miscompares = 0;
        prev_prod = '0;
        rst_n = 1'b0;
        start = 1'b0;
        kill = 1'b0;
        rs1 = '0;
        rs2 = '0;
        #12;
        check_reset_outputs("reset");
        @(negedge clk);
        rst_n = 1'b1;

        run_op(32'd6, 32'd7, 0, 0);
        run_op(32'h1234, 32'd0, 0, 0);
        run_op(32'hFFFF_FFFF, 32'hFFFF_FFFF, 0, 0);
        run_op(32'd3, 32'd5, 2, 0);
        run_op(32'd9, 32'd9, 0, 0);
        run_op(32'd6, 32'd7, 0, 0);
        run_op(32'd100, 32'h80, 0, 3);

        // Asynchronous reset in the middle of a long multiply
        @(negedge clk);
        start = 1'b1;
        rs1 = 32'h0000_FFFF;
        rs2 = 32'h0000_FFFF;
        @(negedge clk);
        start = 1'b0;
        repeat (3) @(negedge clk);
        check("busy_before_reset", N'(busy), N'(1));
        @(posedge clk);
        #2 rst_n = 1'b0;
        #1 check_reset_outputs("async_reset");
        @(negedge clk);
        rst_n = 1'b1;
        prev_prod = '0;
        run_op(32'd2, 32'd3, 0, 0);

        for (int i = 0; i < 30; i++) begin
            ra = $urandom;
            rb = $urandom >> $urandom_range(0, 31);
            if (i % 10 == 0) rb = '0;
            run_op(ra, rb, 0, 0);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/alu_mul_seq.md
# alu_mul_seq

Multi-cycle sequencer that computes RV32M `MUL` (low N bits of rs1 × rs2) by borrowing the shared ALU's adder for one shift-add step per cycle. It sits beside the ALU in the execute stage. While the sequencer owns the ALU, it asserts `alu_req` and the top level steers the ALU's `sel`/`a`/`b` from this block. No second adder is instantiated.

## Interface
- `N`, default 32: operand/result width; must be ≥2.
- `clk`  in  1  rising-edge clock.
- `rst_n`  in  1  reset; asynchronous, active-low.
- `start`  in  1  one-cycle request; sampled only in IDLE.
- `kill`  in  1  synchronous abort; ignored in IDLE.
- `rs1`  in  N  multiplicand; sampled with `start`.
- `rs2`  in  N  multiplier; sampled with `start`.
- `alu_out`  in  N  result from the shared ALU (combinational path).
- `alu_req`  out  1  high while the ALU is owned (RUN state only).
- `alu_sel`  out  4  ALU opcode; ADD (4'b0010) in RUN, 4'b0010 otherwise.
- `alu_a`  out  N  accumulator in RUN; 0 otherwise.
- `alu_b`  out  N  shifted multiplicand in RUN; 0 otherwise.
- `busy`  out  1  high in RUN and DONE.
- `done`  out  1  one-cycle pulse in DONE.
- `product`  out  N  result; valid from `done` until the next accepted `start`.

## Operation
- States: IDLE, RUN, DONE.
- Internal registers: `acc` (N), `mcand` (N), `mplier` (N), `cnt` (log2 N bits).
- IDLE, `start`=1:
  - `acc`←0, `mcand`←rs1, `mplier`←rs2, `cnt`←0.
  - Next state is DONE if rs2==0, else RUN.
- RUN, each cycle:
  - Drives `alu_sel`=ADD, `alu_a`=acc, `alu_b`=mcand.
  - At the edge: if `mplier[0]`, `acc`←alu_out; `mcand`←mcand<<1; `mplier`←mplier>>1; `cnt`++.
  - Exit to DONE when (mplier>>1)==0 or `cnt`==N-1.
- DONE:
  - `product`←acc is registered on entry.
  - `done`=1 for this single cycle, then the block returns to IDLE.
- Arithmetic is modulo 2^N. Carry-out is discarded and signedness is irrelevant for the low half.
- `start` while busy is ignored and not queued.
- `kill` in RUN or DONE:
  - Next state is IDLE; `done` is not asserted in the following cycle.
  - `product` keeps its previous value.
  - `kill` has priority over the RUN→DONE transition.
- `start` and `kill` together in IDLE: `start` wins.
- Async reset at any time: IDLE, and every register (including `product`) is cleared.

## Timing
- Reset values: `alu_req`=0, `busy`=0, `done`=0, `product`=0, `alu_sel`=4'b0010, `alu_a`=0, `alu_b`=0.
- Let `start` be accepted at edge E0, and let k = index of the highest set bit of rs2, plus 1 (k=0 for rs2==0).
- RUN occupies k cycles, starting the cycle after E0.
- `done` is high in cycle k+1 after E0; `product` is valid in that same cycle.
- Minimum latency is 1 cycle (rs2==0). Maximum is N+1 cycles (rs2 MSB set).
- The earliest next `start` is accepted in the cycle after DONE, so back-to-back throughput is k+2 cycles per op.
- `alu_req`, `alu_sel`, `alu_a` and `alu_b` are registered-state decodes.
  - The only combinational path is `alu_out` → `acc` D-input.
  - This path must meet the single-cycle ALU timing.

## Structure
- Shared package `alu_pkg`:
  - ALU opcode constants: `ALU_AND`=4'b0000, `ALU_OR`=4'b0001, `ALU_ADD`=4'b0010, `ALU_SUB`=4'b0110.
  - Sequencer state encoding.
  - The ALU decoder and this block both import it.
- No sub-module. The ALU is instantiated at the top level, and the top-level mux selects sequencer inputs when `alu_req`=1.

## Test plan
- rs1=6, rs2=7 (k=3): `alu_req` high for exactly 3 cycles, `done` in cycle 4, `product`=42.
- rs1=0x1234, rs2=0: no RUN cycles, `alu_req` never high, `done` in cycle 1, `product`=0.
- rs1=rs2=0xFFFFFFFF: 32 RUN cycles, `done` in cycle 33, `product`=0x00000001 (wrap-around).
- 3×5 running, `start` with rs1=9, rs2=9 pulsed mid-RUN: ignored; `product`=15, then an idle-start 9×9 gives 81.
- rs1=100, rs2=0x80, `kill` in 3rd RUN cycle: IDLE next cycle, no `done`, `product` unchanged (prior 42); `alu_req`=0.
- `rst_n` low asynchronously mid-RUN: all outputs reach reset values without a clock edge; after release, 2×3 gives `product`=6.
